// File: rtl/ad7383_pkg.sv
// Shared types and default constants for the AD7383 capture sequencer.
package ad7383_pkg;

  localparam int INIT_TIMEOUT_DEF = 4096;
  localparam int RST_CYCLES_DEF   = 4;

  typedef enum logic [2:0] {
    ST_ADC_RST = 3'd0,
    ST_INIT    = 3'd1,
    ST_IDLE    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_FAULT   = 3'd5
  } ctrl_state_e;

  // Field order puts channel A in the upper half of the packed word.
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } ad7383_pair_t;

endpackage

// File: rtl/ad7383_sample_slot.sv
// One-entry valid/ready holding register for A/B sample pairs.
module ad7383_sample_slot
  import ad7383_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  ad7383_pair_t load_data,
  input  logic         flush,
  input  logic         ready,
  output logic         valid,
  output ad7383_pair_t data,
  output logic         drop
);

  // A full slot only takes a new word when the old one leaves this cycle.
  assign drop = load && valid && !ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load && (!valid || ready)) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ad7383_capture_ctrl.sv
// AD7383 sequencer: interface reset/init with retries, decimated bursts,
// and a one-entry output stream toward the system FIFO.
module ad7383_capture_ctrl
  import ad7383_pkg::*;
#(
  parameter int INIT_TIMEOUT = INIT_TIMEOUT_DEF,
  parameter int MAX_RETRIES  = 3,
  parameter int RST_CYCLES   = RST_CYCLES_DEF,
  parameter int BURST_W      = 16,
  parameter int DECIM_W      = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               reinit_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic [DECIM_W-1:0] decim_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               overflow_o,
  output logic               init_err_o,
  output logic [1:0]         retry_cnt_o,
  output logic               adc_rst_o,
  output logic               adc_init_o,
  input  logic               adc_ready_i,
  input  logic [15:0]        adc_data_a_i,
  input  logic [15:0]        adc_data_b_i,
  input  logic               adc_valid_i,
  output logic [31:0]        m_data_o,
  output logic               m_valid_o,
  input  logic               m_ready_i
);

  localparam int TMO_W = $clog2(INIT_TIMEOUT);
  localparam int RST_W = $clog2(RST_CYCLES + 1);

  ctrl_state_e        state;
  logic [RST_W-1:0]   rst_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [1:0]         retry_cnt;
  logic [BURST_W-1:0] burst_len_q;
  logic [BURST_W-1:0] kept_cnt;
  logic [DECIM_W-1:0] decim_q;
  logic [DECIM_W-1:0] dec_cnt;
  logic               overflow_q;
  logic               done_q;

  logic               ready_lost;
  logic               keep;
  logic               burst_end;
  logic               slot_drop;
  ad7383_pair_t       slot_data;
  ad7383_pair_t       sample;

  assign sample     = '{a: adc_data_a_i, b: adc_data_b_i};
  assign ready_lost = !adc_ready_i &&
                      (state == ST_IDLE || state == ST_CAPTURE || state == ST_DRAIN);
  // An abort or ready loss ends capture in the same cycle, so that strobe is not kept.
  assign keep       = (state == ST_CAPTURE) && adc_valid_i && (dec_cnt == '0) &&
                      !abort_i && adc_ready_i;
  assign burst_end  = keep && (burst_len_q != '0) && (kept_cnt + 1'b1 == burst_len_q);

  ad7383_sample_slot u_slot (
    .clk       (clk_i),
    .rst       (rst_i),
    .load      (keep),
    .load_data (sample),
    .flush     (ready_lost),
    .ready     (m_ready_i),
    .valid     (m_valid_o),
    .data      (slot_data),
    .drop      (slot_drop)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_ADC_RST;
      rst_cnt     <= '0;
      tmo_cnt     <= '0;
      retry_cnt   <= '0;
      burst_len_q <= '0;
      kept_cnt    <= '0;
      decim_q     <= '0;
      dec_cnt     <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (state == ST_CAPTURE && adc_valid_i)
        dec_cnt <= (dec_cnt == decim_q - 1'b1) ? '0 : dec_cnt + 1'b1;

      // Dropped samples still count toward the burst length.
      if (keep) begin
        kept_cnt <= kept_cnt + 1'b1;
        if (slot_drop) overflow_q <= 1'b1;
      end

      case (state)
        ST_ADC_RST: begin
          if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
            rst_cnt <= '0;
            tmo_cnt <= '0;
            state   <= ST_INIT;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        ST_INIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (adc_ready_i) begin
            state <= ST_IDLE;
          end else if (tmo_cnt == TMO_W'(INIT_TIMEOUT - 1)) begin
            if (retry_cnt < 2'(MAX_RETRIES)) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= ST_ADC_RST;
            end else begin
              state <= ST_FAULT;
            end
          end
        end
        ST_FAULT: begin
          if (reinit_i) begin
            retry_cnt <= '0;
            state     <= ST_ADC_RST;
          end
        end
        ST_IDLE: begin
          if (ready_lost) begin
            retry_cnt <= '0;
            state     <= ST_ADC_RST;
          end else if (start_i && !abort_i) begin
            burst_len_q <= burst_len_i;
            decim_q     <= (decim_i == '0) ? DECIM_W'(1) : decim_i;
            kept_cnt    <= '0;
            dec_cnt     <= '0;
            overflow_q  <= 1'b0;
            state       <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (ready_lost) begin
            retry_cnt <= '0;
            state     <= ST_ADC_RST;
          end else if (abort_i) begin
            state <= ST_IDLE;
          end else if (burst_end) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (ready_lost) begin
            retry_cnt <= '0;
            state     <= ST_ADC_RST;
          end else if (abort_i) begin
            state <= ST_IDLE;
          end else if (!m_valid_o || m_ready_i) begin
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_ADC_RST;
      endcase
    end
  end

  // NOTE: state-decoded outputs are combinational so the async reset drives
  // adc_rst_o high immediately, and rst/init swap on one edge.
  assign adc_rst_o   = (state == ST_ADC_RST);
  assign adc_init_o  = (state == ST_INIT);
  assign init_err_o  = (state == ST_FAULT);
  assign busy_o      = (state == ST_CAPTURE) || (state == ST_DRAIN);
  assign done_o      = done_q;
  assign overflow_o  = overflow_q;
  assign retry_cnt_o = retry_cnt;
  assign m_data_o    = slot_data;

endmodule

// File: tb/tb_ad7383_capture_ctrl.sv
// Directed bench for ad7383_capture_ctrl with a queue scoreboard on the output stream.
module tb_ad7383_capture_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, abort_i, reinit_i;
  logic [15:0] burst_len_i;
  logic [7:0]  decim_i;
  logic        busy_o, done_o, overflow_o, init_err_o;
  logic [1:0]  retry_cnt_o;
  logic        adc_rst_o, adc_init_o, adc_ready_i;
  logic [15:0] adc_data_a_i, adc_data_b_i;
  logic        adc_valid_i;
  logic [31:0] m_data_o;
  logic        m_valid_o, m_ready_i;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic        stall_q = 1'b0;
  logic [31:0] stall_data;

  ad7383_capture_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .reinit_i(reinit_i), .burst_len_i(burst_len_i), .decim_i(decim_i),
    .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o),
    .init_err_o(init_err_o), .retry_cnt_o(retry_cnt_o),
    .adc_rst_o(adc_rst_o), .adc_init_o(adc_init_o), .adc_ready_i(adc_ready_i),
    .adc_data_a_i(adc_data_a_i), .adc_data_b_i(adc_data_b_i),
    .adc_valid_i(adc_valid_i), .m_data_o(m_data_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold stability.
  always @(negedge clk_i) begin
    if (rst_i) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && m_valid_o) check("stall_stable", m_data_o, stall_data);
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", m_data_o, 32'hxxxx_xxxx);
        end else begin
          check("stream_word", m_data_o, exp_q.pop_front());
        end
      end
      stall_q    = m_valid_o && !m_ready_i;
      stall_data = m_data_o;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe(input logic [15:0] a, input logic [15:0] b, input bit expect_word);
    adc_data_a_i = a;
    adc_data_b_i = b;
    adc_valid_i  = 1'b1;
    if (expect_word) exp_q.push_back({a, b});
    tick();
    adc_valid_i = 1'b0;
  endtask

  task automatic start_burst(input logic [15:0] len, input logic [7:0] dec);
    burst_len_i = len;
    decim_i     = dec;
    start_i     = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic measure_rst(output int n);
    n = 0;
    while (adc_rst_o && n < 50) begin tick(); n++; end
  endtask

  task automatic measure_init(output int n);
    n = 0;
    while (adc_init_o && n < 5000) begin tick(); n++; end
  endtask

  initial begin
    int n;
    int seen;
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; reinit_i = 1'b0;
    burst_len_i = '0; decim_i = '0; adc_ready_i = 1'b0;
    adc_data_a_i = '0; adc_data_b_i = '0; adc_valid_i = 1'b0; m_ready_i = 1'b1;

    #1;
    check("rst_adc_rst", adc_rst_o, 1);
    check("rst_adc_init", adc_init_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_m_valid", m_valid_o, 0);
    check("rst_init_err", init_err_o, 0);
    check("rst_retry", retry_cnt_o, 0);
    check("rst_done_ovf", {done_o, overflow_o}, 0);
    idle(3);
    rst_i = 1'b0;

    // Init success after 120 cycles.
    measure_rst(n);
    check("init_rst_width", n, 4);
    check("init_req", adc_init_o, 1);
    idle(120);
    check("init_still_waiting", adc_init_o, 1);
    adc_ready_i = 1'b1;
    tick();
    check("init_ok_idle", adc_init_o, 0);
    check("init_ok_err", init_err_o, 0);
    check("init_ok_retry", retry_cnt_o, 0);

    // Burst of 5 with decimation 3.
    m_ready_i = 1'b1;
    start_burst(5, 3);
    check("burst_busy", busy_o, 1);
    for (int k = 1; k <= 13; k++) begin
      strobe(16'hA000 + 16'(k), 16'hB000 + 16'(k), (k % 3) == 1);
      if (k < 13) idle(19);
    end
    check("burst_drain_busy", busy_o, 1);
    check("burst_done_early", done_o, 0);
    tick();
    check("burst_done", done_o, 1);
    tick();
    check("burst_done_pulse", done_o, 0);
    check("burst_idle", busy_o, 0);
    strobe(16'h1414, 16'h1414, 1'b0);
    idle(3);
    check("idle_ignores_strobe", m_valid_o, 0);

    // Overflow: stall the stream for 45 cycles.
    m_ready_i = 1'b0;
    start_burst(4, 1);
    check("ovf_cleared", overflow_o, 0);
    strobe(16'h0001, 16'h1001, 1'b1);
    idle(19);
    strobe(16'h0002, 16'h1002, 1'b0);
    check("ovf_set", overflow_o, 1);
    idle(19);
    strobe(16'h0003, 16'h1003, 1'b0);
    idle(3);
    m_ready_i = 1'b1;
    idle(16);
    strobe(16'h0004, 16'h1004, 1'b1);
    check("ovf_done_early", done_o, 0);
    tick();
    check("ovf_done", done_o, 1);
    check("ovf_sticky", overflow_o, 1);

    // Abort coincident with the final kept strobe.
    start_burst(2, 1);
    check("abort_ovf_cleared", overflow_o, 0);
    strobe(16'h00AB, 16'h10AB, 1'b1);
    idle(19);
    abort_i = 1'b1;
    strobe(16'h00AC, 16'h10AC, 1'b0);
    abort_i = 1'b0;
    check("abort_idle", busy_o, 0);
    seen = 0;
    repeat (4) begin
      if (done_o) seen++;
      tick();
    end
    check("abort_no_done", seen, 0);

    // Ready loss mid-capture discards the pending word.
    m_ready_i = 1'b0;
    start_burst(0, 1);
    strobe(16'h0DEA, 16'h0DEB, 1'b0);
    check("rl_pending", m_valid_o, 1);
    idle(5);
    adc_ready_i = 1'b0;
    tick();
    check("rl_adc_rst", adc_rst_o, 1);
    check("rl_busy", busy_o, 0);
    check("rl_flush", m_valid_o, 0);
    check("rl_retry", retry_cnt_o, 0);
    m_ready_i = 1'b1;
    measure_rst(n);
    check("rl_rst_width", n, 4);
    adc_ready_i = 1'b1;
    tick();
    check("rl_reinit_idle", adc_init_o, 0);

    // Asynchronous reset in the middle of a capture.
    m_ready_i = 1'b0;
    start_burst(0, 1);
    strobe(16'h0A5A, 16'h05A5, 1'b0);
    check("ar_pending", m_valid_o, 1);
    #2 rst_i = 1'b1;
    #1;
    check("ar_adc_rst", adc_rst_o, 1);
    check("ar_m_valid", m_valid_o, 0);
    check("ar_busy", busy_o, 0);
    adc_ready_i = 1'b0;
    m_ready_i   = 1'b1;
    idle(2);
    rst_i = 1'b0;

    // Init failure: four reset/timeout rounds, then Fault.
    for (int r = 0; r < 4; r++) begin
      measure_rst(n);
      check($sformatf("fail_rst_width_%0d", r), n, 4);
      measure_init(n);
      check($sformatf("fail_timeout_%0d", r), n, 4096);
      if (r < 3) begin
        check($sformatf("fail_retry_%0d", r), retry_cnt_o, r + 1);
        check($sformatf("fail_rearm_%0d", r), adc_rst_o, 1);
      end
    end
    check("fault_err", init_err_o, 1);
    check("fault_retry", retry_cnt_o, 3);
    idle(10);
    check("fault_holds", init_err_o, 1);
    reinit_i = 1'b1;
    tick();
    reinit_i = 1'b0;
    check("reinit_adc_rst", adc_rst_o, 1);
    check("reinit_err_clr", init_err_o, 0);
    check("reinit_retry_clr", retry_cnt_o, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
